// File: rtl/trace_capture_buffer_if.sv
// Drain-side valid/ready port of the trace capture buffer.
// The buffer is the master; the trace reader is the slave.
interface trace_capture_buffer_if #(
    parameter int DW = 32
) ();
    logic              rd_valid;
    logic              rd_ready;
    logic [2*DW+4:0]   rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Retirement-trace recorder: circular capture of decode-stage samples,
// frozen a fixed number of entries after a PC-match trigger, drained oldest-first.
module trace_capture_buffer #(
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    localparam int PTRW     = $clog2(DEPTH),
    localparam int EW       = 2*DW+5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  clear_i,
    input  logic                  trig_en_i,
    input  logic [DW-1:0]         trig_pc_i,
    input  logic                  valid_i,
    input  logic [DW-1:0]         pc_i,
    input  logic [DW-1:0]         instr_i,
    input  logic [1:0]            fwd_a_i,
    input  logic [1:0]            fwd_b_i,
    input  logic                  reg_write_i,
    trace_capture_buffer_if.master rd,
    output logic [PTRW:0]         count_o,
    output logic                  trig_hit_o,
    output logic                  done_o,
    output logic                  overflow_o
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [PTRW:0]   FULL    = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   ONE_C   = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] ONE_P   = PTRW'(1);
    localparam logic [PTRW-1:0] POST_LD = PTRW'(POST_TRIG);

    logic [1:0]      state_q, state_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic [PTRW-1:0] post_q, post_d;
    logic            ovf_q, ovf_d;
    logic            trig_q, trig_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic            recording;
    logic            we;
    logic            trig_match;
    logic [PTRW-1:0] rd_ptr;
    logic            rd_valid;
    logic            xfer;

    assign recording  = (state_q == S_CAPTURE) || (state_q == S_POST);
    assign we         = recording && valid_i && !clear_i;
    assign trig_match = trig_en_i && (pc_i == trig_pc_i);
    // Oldest entry sits count slots behind the write pointer; a full
    // buffer truncates count to zero and reads from wr_ptr itself.
    assign rd_ptr     = wr_ptr_q - count_q[PTRW-1:0];
    assign rd_valid   = (state_q == S_DONE) && (count_q != '0);
    assign xfer       = rd_valid && rd.rd_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        ovf_d    = ovf_q;
        trig_d   = 1'b0;

        if (recording && valid_i) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
            if (count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + ONE_C;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    state_d  = S_CAPTURE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (valid_i && trig_match) begin
                    trig_d  = 1'b1;
                    post_d  = POST_LD;
                    state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (valid_i) begin
                    post_d = post_q - ONE_P;
                    if (post_q == ONE_P) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (xfer) begin
                    count_d = count_q - ONE_C;
                    if (count_q == ONE_C) begin
                        state_d = S_IDLE;
                        ovf_d   = 1'b0;
                    end
                end
            end
        endcase

        if (clear_i) begin
            state_d = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            trig_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            ovf_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            ovf_q    <= ovf_d;
            trig_q   <= trig_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[wr_ptr_q] <= {pc_i, instr_i, fwd_a_i, fwd_b_i, reg_write_i};
        end
    end

    assign rd.rd_valid = rd_valid;
    assign rd.rd_data  = mem_q[rd_ptr];
    assign count_o     = count_q;
    assign trig_hit_o  = trig_q;
    assign done_o      = (state_q == S_DONE);
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: two instances (POST_TRIG 4 and 0) share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_trace_capture_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int EW    = 2*DW+5;

    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_POST = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst, arm, clr, ten, vld, rw, rdy;
    logic [DW-1:0] tpc, pc, ins;
    logic [1:0]    fa, fb;

    logic [4:0]    cnt0, cnt1;
    logic          th0, th1, dn0, dn1, ov0, ov1;

    int checks   = 0;
    int failures = 0;

    trace_capture_buffer_if #(.DW(DW)) rd0 ();
    trace_capture_buffer_if #(.DW(DW)) rd1 ();
    assign rd0.rd_ready = rdy;
    assign rd1.rd_ready = rdy;

    trace_capture_buffer #(.DW(DW), .DEPTH(DEPTH), .POST_TRIG(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clr),
        .trig_en_i(ten), .trig_pc_i(tpc), .valid_i(vld), .pc_i(pc),
        .instr_i(ins), .fwd_a_i(fa), .fwd_b_i(fb), .reg_write_i(rw),
        .rd(rd0.master), .count_o(cnt0), .trig_hit_o(th0),
        .done_o(dn0), .overflow_o(ov0)
    );

    trace_capture_buffer #(.DW(DW), .DEPTH(DEPTH), .POST_TRIG(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clr),
        .trig_en_i(ten), .trig_pc_i(tpc), .valid_i(vld), .pc_i(pc),
        .instr_i(ins), .fwd_a_i(fa), .fwd_b_i(fb), .reg_write_i(rw),
        .rd(rd1.master), .count_o(cnt1), .trig_hit_o(th1),
        .done_o(dn1), .overflow_o(ov1)
    );

    always #5 clk = ~clk;

    // Reference model: the captured window is a plain FIFO of entries.
    logic [EW-1:0] mq0[$];
    logic [EW-1:0] mq1[$];
    int            mode [2];
    int            post [2];
    bit            movf [2];
    bit            mtrig[2];

    function automatic int msize(int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [EW-1:0] mfront(int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic mclear(int k);
        if (k == 0) mq0.delete();
        else        mq1.delete();
    endtask

    task automatic mpop(int k);
        if (k == 0) void'(mq0.pop_front());
        else        void'(mq1.pop_front());
    endtask

    task automatic mpush(int k, logic [EW-1:0] e);
        if (msize(k) == DEPTH) begin
            mpop(k);
            movf[k] = 1'b1;
        end
        if (k == 0) mq0.push_back(e);
        else        mq1.push_back(e);
    endtask

    task automatic model_edge(int k, int pt);
        logic [EW-1:0] e;
        e = {pc, ins, fa, fb, rw};
        mtrig[k] = 1'b0;
        if (rst || clr) begin
            mode[k] = M_IDLE;
            mclear(k);
            movf[k] = 1'b0;
        end else begin
            case (mode[k])
                M_IDLE: if (arm) begin
                    mode[k] = M_CAP;
                    mclear(k);
                    movf[k] = 1'b0;
                end
                M_CAP: if (vld) begin
                    mpush(k, e);
                    if (ten && pc == tpc) begin
                        mtrig[k] = 1'b1;
                        post[k]  = pt;
                        mode[k]  = (pt == 0) ? M_DONE : M_POST;
                    end
                end
                M_POST: if (vld) begin
                    mpush(k, e);
                    post[k]--;
                    if (post[k] == 0) mode[k] = M_DONE;
                end
                default: if (rdy && msize(k) > 0) begin
                    mpop(k);
                    if (msize(k) == 0) begin
                        mode[k] = M_IDLE;
                        movf[k] = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic compare(int k, logic [4:0] c, logic t, logic d,
                           logic o, logic v, logic [EW-1:0] data);
        bit ev;
        ev = (mode[k] == M_DONE) && (msize(k) > 0);
        chk($sformatf("m%0d_count", k), c, msize(k));
        chk($sformatf("m%0d_trig", k), t, mtrig[k]);
        chk($sformatf("m%0d_done", k), d, mode[k] == M_DONE);
        chk($sformatf("m%0d_ovf", k), o, movf[k]);
        chk($sformatf("m%0d_rdvalid", k), v, ev);
        if (ev) chk($sformatf("m%0d_rddata", k), data, mfront(k));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, 4);
        model_edge(1, 0);
        #1;
        compare(0, cnt0, th0, dn0, ov0, rd0.rd_valid, rd0.rd_data);
        compare(1, cnt1, th1, dn1, ov1, rd1.rd_valid, rd1.rd_data);
    endtask

    task automatic drv(bit a, bit c, bit v, logic [DW-1:0] p, bit r);
        arm = a;
        clr = c;
        vld = v;
        pc  = p;
        rdy = r;
        ins = $urandom;
        fa  = 2'($urandom);
        fb  = 2'($urandom);
        rw  = 1'($urandom);
    endtask

    typedef struct {
        bit            a;
        bit            v;
        bit            r;
        logic [DW-1:0] p;
        int            ecnt;
        bit            edn;
        bit            etr;
        bit            erv;
        logic [DW-1:0] epc;
    } vec_t;

    vec_t tv[15];

    initial begin
        int n;
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  0, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 32'd4,  2, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 32'd8,  3, 1'b0, 1'b1, 1'b0, 32'd0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 32'd12, 4, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 32'd16, 5, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 32'd20, 6, 1'b0, 1'b0, 1'b0, 32'd0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 32'd24, 7, 1'b1, 1'b0, 1'b1, 32'd0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 32'd0,  6, 1'b1, 1'b0, 1'b1, 32'd4};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'd0,  5, 1'b1, 1'b0, 1'b1, 32'd8};
        tv[10] = '{1'b0, 1'b0, 1'b1, 32'd0,  4, 1'b1, 1'b0, 1'b1, 32'd12};
        tv[11] = '{1'b0, 1'b0, 1'b1, 32'd0,  3, 1'b1, 1'b0, 1'b1, 32'd16};
        tv[12] = '{1'b0, 1'b0, 1'b1, 32'd0,  2, 1'b1, 1'b0, 1'b1, 32'd20};
        tv[13] = '{1'b0, 1'b0, 1'b1, 32'd0,  1, 1'b1, 1'b0, 1'b1, 32'd24};
        tv[14] = '{1'b0, 1'b0, 1'b1, 32'd0,  0, 1'b0, 1'b0, 1'b0, 32'd0};

        rst = 1'b1;
        ten = 1'b1;
        tpc = 32'd8;
        drv(0, 0, 0, 0, 0);
        post[0] = 0;
        post[1] = 0;

        // Reset
        tick();
        tick();
        chk("rst_count", cnt0, 0);
        chk("rst_rdvalid", rd0.rd_valid, 0);
        chk("rst_done", dn0, 0);
        chk("rst_ovf", ov0, 0);
        chk("rst_trig", th0, 0);
        rst = 1'b0;

        // Basic window, table driven
        for (int i = 0; i < 15; i++) begin
            drv(tv[i].a, 0, tv[i].v, tv[i].p, tv[i].r);
            tick();
            chk($sformatf("win_count[%0d]", i), cnt0, tv[i].ecnt);
            chk($sformatf("win_done[%0d]", i), dn0, tv[i].edn);
            chk($sformatf("win_trig[%0d]", i), th0, tv[i].etr);
            chk($sformatf("win_rdv[%0d]", i), rd0.rd_valid, tv[i].erv);
            if (tv[i].erv)
                chk($sformatf("win_pc[%0d]", i), rd0.rd_data[EW-1:EW-DW], tv[i].epc);
        end
        drv(0, 1, 0, 0, 0);
        tick();

        // Wrap: 24 writes into 16 slots
        tpc = 32'd76;
        drv(1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 24; i++) begin
            drv(0, 0, 1, 32'(4*i), 0);
            tick();
        end
        chk("wrap_count", cnt0, 16);
        chk("wrap_ovf", ov0, 1);
        chk("wrap_done", dn0, 1);

        // Backpressure drain: expected PC advances only on accepted beats
        n = 0;
        for (int c = 0; c < 34; c++) begin
            drv(0, 0, 0, 0, c[0]);
            #0;
            if (n < 16)
                chk($sformatf("bp_pc[%0d]", n), rd0.rd_data[EW-1:EW-DW], 32'(32 + 4*n));
            tick();
            if (rdy && n < 16) n++;
        end
        chk("bp_count", cnt0, 0);
        chk("bp_done", dn0, 0);
        chk("bp_ovf", ov0, 0);

        // Abort in POST, then arm+clear together
        tpc = 32'h200;
        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 1, 32'h200, 0);
        tick();
        drv(0, 0, 1, 32'h204, 0);
        tick();
        drv(0, 1, 1, 32'h208, 0);
        tick();
        chk("abort_count", cnt0, 0);
        chk("abort_done", dn0, 0);
        drv(1, 1, 0, 0, 0);
        tick();
        drv(0, 0, 1, 32'h20c, 0);
        tick();
        chk("armclr_count", cnt0, 0);
        chk("armclr_done", dn0, 0);

        // Bubbles and zero post-trigger
        tpc = 32'h308;
        drv(1, 0, 0, 0, 0);
        tick();
        drv(0, 0, 1, 32'h300, 0); tick();
        drv(0, 0, 0, 32'h308, 0); tick();
        drv(0, 0, 1, 32'h304, 0); tick();
        drv(0, 0, 0, 32'h308, 0); tick();
        drv(0, 0, 1, 32'h308, 0); tick();
        chk("zp_done", dn1, 1);
        chk("zp_count", cnt1, 3);
        drv(0, 0, 0, 32'h30c, 0); tick();
        chk("bub_count", cnt0, 3);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 1, 32'(32'h310 + 4*i), 0); tick();
            drv(0, 0, 0, 32'h0, 0); tick();
        end
        chk("bub_done", dn0, 1);
        chk("bub_count7", cnt0, 7);
        drv(0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 1); tick();
        chk("zp_lastpc", rd1.rd_data[EW-1:EW-DW], 32'h308);
        chk("zp_left", cnt1, 1);
        drv(0, 1, 0, 0, 0); tick();

        // Randomized traffic against the model
        tpc = 32'h20;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            drv($urandom_range(5) == 0, $urandom_range(79) == 0,
                $urandom_range(2) != 0, 32'(4*$urandom_range(15)),
                1'($urandom));
            ten = ($urandom_range(7) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
